// File: rtl/v0_display_driver_if.sv
// Bus between the CPU-side $v0 tap and the 7-segment display driver.
// The driver is the slave: it consumes the value/mode and produces the
// multiplexed segment/digit drive plus status.
interface v0_display_driver_if;
    logic [31:0] value_in;
    logic        hex_mode_in;
    logic [6:0]  seg_out;
    logic [3:0]  digit_out;
    logic        overflow_out;
    logic        busy_out;

    modport master (
        output value_in, hex_mode_in,
        input  seg_out, digit_out, overflow_out, busy_out
    );

    modport slave (
        input  value_in, hex_mode_in,
        output seg_out, digit_out, overflow_out, busy_out
    );
endinterface

// File: rtl/v0_display_driver.sv
// 4-digit common-anode 7-segment driver for the CPU $v0 tap.
// Captures value/mode on change, converts to BCD with a 32-step
// double-dabble engine (or passes hex through), and scans the digits.

// One BCD digit of the double-dabble adjust step: add 3 when >= 5.
module v0_dd_bcd_adj (
    input  logic [3:0] nib_in,
    output logic [3:0] nib_out
);
    assign nib_out = (nib_in >= 4'd5) ? nib_in + 4'd3 : nib_in;
endmodule

module v0_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset_in,
    v0_display_driver_if.slave bus
);
    localparam int BCD_DIGITS = 10;   // 2^32-1 has ten decimal digits
    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {IDLE, CONVERT, LOAD} state_t;

    state_t                           state_q, state_d;
    logic [31:0]                      cap_val_q;
    logic                             cap_mode_q;
    logic [31:0]                      shift_q;
    logic [BCD_DIGITS-1:0][3:0]       bcd_q;
    logic [BCD_DIGITS-1:0][3:0]       bcd_adj;
    logic [4*BCD_DIGITS-1:0]          bcd_adj_flat;
    logic [4:0]                       iter_q;
    logic [NUM_DIGITS-1:0][3:0]       disp_q;
    logic                             ovf_q;
    logic [1:0]                       idx_q;
    logic [CNT_W-1:0]                 ref_cnt_q;
    logic                             changed;
    logic [3:0]                       cur_nib;

    assign changed = {bus.value_in, bus.hex_mode_in} != {cap_val_q, cap_mode_q};

    // Per-digit add-3 adjust, applied to the whole accumulator before each shift.
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_adj
        v0_dd_bcd_adj u_adj (
            .nib_in  (bcd_q[g]),
            .nib_out (bcd_adj[g])
        );
    end
    assign bcd_adj_flat = bcd_adj;

    // FSM state register.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Next state: hex goes straight to LOAD, decimal runs 32 shifts first.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (changed) state_d = bus.hex_mode_in ? LOAD : CONVERT;
            CONVERT: if (iter_q == 5'd31) state_d = LOAD;
            LOAD:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Capture, conversion datapath and display latch. The display only
    // changes in LOAD, so it holds the previous result during a conversion.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            cap_val_q  <= '0;
            cap_mode_q <= 1'b0;
            shift_q    <= '0;
            bcd_q      <= '0;
            iter_q     <= '0;
            disp_q     <= '0;
            ovf_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (changed) begin
                        cap_val_q  <= bus.value_in;
                        cap_mode_q <= bus.hex_mode_in;
                        shift_q    <= bus.value_in;
                        bcd_q      <= '0;
                        iter_q     <= '0;
                    end
                end
                CONVERT: begin
                    bcd_q   <= {bcd_adj_flat[4*BCD_DIGITS-2:0], shift_q[31]};
                    shift_q <= {shift_q[30:0], 1'b0};
                    iter_q  <= iter_q + 5'd1;
                end
                LOAD: begin
                    if (cap_mode_q) begin
                        disp_q <= cap_val_q[15:0];
                        ovf_q  <= |cap_val_q[31:16];
                    end else begin
                        disp_q <= bcd_q[NUM_DIGITS-1:0];
                        ovf_q  <= |bcd_q[BCD_DIGITS-1:NUM_DIGITS];
                    end
                end
                default: ;
            endcase
        end
    end

    // Free-running refresh counter; advances the active digit at terminal count.
    always_ff @(posedge clk or posedge reset_in) begin
        if (reset_in) begin
            ref_cnt_q <= '0;
            idx_q     <= '0;
        end else if (ref_cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            ref_cnt_q <= '0;
            idx_q     <= idx_q + 2'd1;
        end else begin
            ref_cnt_q <= ref_cnt_q + 1'b1;
        end
    end

    assign cur_nib          = disp_q[idx_q];
    assign bus.digit_out    = ~(4'b0001 << idx_q);
    assign bus.overflow_out = ovf_q;
    assign bus.busy_out     = (state_q != IDLE);

    // Active-low glyph for the selected nibble, a = bit 6 ... g = bit 0.
    always_comb begin
        bus.seg_out = 7'b1111111;
        case (cur_nib)
            4'h0: bus.seg_out = 7'b0000001;
            4'h1: bus.seg_out = 7'b1001111;
            4'h2: bus.seg_out = 7'b0010010;
            4'h3: bus.seg_out = 7'b0000110;
            4'h4: bus.seg_out = 7'b1001100;
            4'h5: bus.seg_out = 7'b0100100;
            4'h6: bus.seg_out = 7'b0100000;
            4'h7: bus.seg_out = 7'b0001111;
            4'h8: bus.seg_out = 7'b0000000;
            4'h9: bus.seg_out = 7'b0000100;
            4'hA: bus.seg_out = 7'b0001000;
            4'hB: bus.seg_out = 7'b1100000;
            4'hC: bus.seg_out = 7'b0110001;
            4'hD: bus.seg_out = 7'b1000010;
            4'hE: bus.seg_out = 7'b0110000;
            4'hF: bus.seg_out = 7'b0111000;
            default: bus.seg_out = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_v0_display_driver.sv
// Directed bench for v0_display_driver with a short refresh period.
module tb_v0_display_driver;
    logic clk = 1'b0;
    logic reset_in = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    v0_display_driver_if bus ();

    v0_display_driver #(.REFRESH_DIV(4), .CNT_W(16)) dut (
        .clk      (clk),
        .reset_in (reset_in),
        .bus      (bus)
    );

    typedef struct {
        logic [31:0] val;
        logic        hex;
        logic [15:0] disp;
        logic        ovf;
        int          lat;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] glyph(input logic [3:0] n);
        case (n)
            4'h0: return 7'b0000001;  4'h1: return 7'b1001111;
            4'h2: return 7'b0010010;  4'h3: return 7'b0000110;
            4'h4: return 7'b1001100;  4'h5: return 7'b0100100;
            4'h6: return 7'b0100000;  4'h7: return 7'b0001111;
            4'h8: return 7'b0000000;  4'h9: return 7'b0000100;
            4'hA: return 7'b0001000;  4'hB: return 7'b1100000;
            4'hC: return 7'b0110001;  4'hD: return 7'b1000010;
            4'hE: return 7'b0110000;  default: return 7'b0111000;
        endcase
    endfunction

    // Counts negedges with busy high; caller is already past E0.
    task automatic count_busy(output int c);
        c = 0;
        while (bus.busy_out && c < 200) begin
            c++;
            @(negedge clk);
        end
    endtask

    // Waits for each digit to become active and checks its glyph.
    task automatic scan_check(input string name, input logic [15:0] exp);
        logic [3:0] dsel;
        logic [3:0] nib;
        int t;
        for (int i = 0; i < 4; i++) begin
            dsel = ~(4'b0001 << i);
            nib  = exp[4*i +: 4];
            t = 0;
            while (bus.digit_out !== dsel && t < 40) begin
                t++;
                @(negedge clk);
            end
            check({name, "_digit"}, {28'd0, bus.digit_out}, {28'd0, dsel});
            check({name, "_seg"}, {25'd0, bus.seg_out}, {25'd0, glyph(nib)});
        end
    endtask

    // Applies a value at a negedge and returns the busy length.
    task automatic apply(input logic [31:0] v, input logic h, output int c);
        bus.value_in    = v;
        bus.hex_mode_in = h;
        @(negedge clk);
        count_busy(c);
    endtask

    initial begin
        int c;
        logic [3:0] seq[4];

        vecs[0] = '{32'd1234,       1'b0, 16'h1234, 1'b0, 33};
        vecs[1] = '{32'd12345,      1'b0, 16'h2345, 1'b1, 33};
        vecs[2] = '{32'd9999,       1'b0, 16'h9999, 1'b0, 33};
        vecs[3] = '{32'h0001ABCD,   1'b1, 16'hABCD, 1'b1, 1};
        vecs[4] = '{32'h000000FF,   1'b1, 16'h00FF, 1'b0, 1};
        vecs[5] = '{32'd0,          1'b0, 16'h0000, 1'b0, 33};
        seq[0] = 4'b1011; seq[1] = 4'b0111; seq[2] = 4'b1110; seq[3] = 4'b1101;

        bus.value_in    = 32'd0;
        bus.hex_mode_in = 1'b0;
        repeat (3) @(negedge clk);
        reset_in = 1'b0;
        #1;
        check("rst_digit", {28'd0, bus.digit_out}, 32'hE);
        check("rst_seg", {25'd0, bus.seg_out}, 32'h01);
        check("rst_ovf", {31'd0, bus.overflow_out}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("rst_idle_busy", {31'd0, bus.busy_out}, 32'd0);
        end

        for (int i = 0; i < 6; i++) begin
            apply(vecs[i].val, vecs[i].hex, c);
            check($sformatf("v%0d_latency", i), c, vecs[i].lat);
            check($sformatf("v%0d_ovf", i), {31'd0, bus.overflow_out}, {31'd0, vecs[i].ovf});
            scan_check($sformatf("v%0d", i), vecs[i].disp);
            if (i == 0) begin
                // Digit enable steps every REFRESH_DIV clocks.
                c = 0;
                while (bus.digit_out !== 4'b1110 && c < 40) begin c++; @(negedge clk); end
                c = 0;
                while (bus.digit_out !== 4'b1101 && c < 40) begin c++; @(negedge clk); end
                check("step_start", {28'd0, bus.digit_out}, 32'hD);
                for (int k = 0; k < 4; k++) begin
                    repeat (4) @(negedge clk);
                    check("step", {28'd0, bus.digit_out}, {28'd0, seq[k]});
                end
            end
        end

        // Input change mid-conversion: first run finishes with 100, then reruns.
        bus.value_in = 32'd100;
        @(negedge clk);
        c = 0;
        while (bus.busy_out && c < 200) begin
            c++;
            if (c == 10) bus.value_in = 32'd200;
            @(negedge clk);
        end
        check("chg_first_latency", c, 33);
        check("chg_gap_busy", {31'd0, bus.busy_out}, 32'd0);
        @(negedge clk);
        check("chg_restart_busy", {31'd0, bus.busy_out}, 32'd1);
        count_busy(c);
        check("chg_second_latency", c, 33);
        check("chg_ovf", {31'd0, bus.overflow_out}, 32'd0);
        scan_check("chg", 16'h0200);

        // Asynchronous reset in the middle of a conversion.
        bus.value_in = 32'd5678;
        @(negedge clk);
        repeat (19) @(negedge clk);
        @(posedge clk);
        #2 reset_in = 1'b1;
        #1;
        check("arst_busy", {31'd0, bus.busy_out}, 32'd0);
        check("arst_digit", {28'd0, bus.digit_out}, 32'hE);
        check("arst_seg", {25'd0, bus.seg_out}, 32'h01);
        check("arst_ovf", {31'd0, bus.overflow_out}, 32'd0);
        @(negedge clk);
        reset_in = 1'b0;
        @(negedge clk);
        count_busy(c);
        check("arst_rerun_latency", c, 33);
        scan_check("arst", 16'h5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
